// File: rtl/count_rate_pkg.sv
// rtl/count_rate_pkg.sv - shared states, mode and step constants for count_rate_monitor
package count_rate_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic       MODE_SLOW = 1'b0;
    localparam logic       MODE_FAST = 1'b1;
    localparam logic [7:0] STEP_SLOW = 8'd1;
    localparam logic [7:0] STEP_FAST = 8'd4;

    function automatic logic [7:0] step_for(input logic mode);
        return (mode == MODE_FAST) ? STEP_FAST : STEP_SLOW;
    endfunction

endpackage

// File: rtl/count_interval_meter.sv
// rtl/count_interval_meter.sv - change detect, step delta and saturating interval measurement
module count_interval_meter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       count_i,
    output logic             change_o,
    output logic [7:0]       delta_o,
    output logic [CNT_W-1:0] interval_o,
    output logic [CNT_W-1:0] last_period_o
);

    logic             primed_q;
    logic [7:0]       prev_q;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] last_q, last_d;

    // primed masks the comparison against the reset value of prev_q
    assign change_o      = primed_q && (count_i != prev_q);
    assign delta_o       = count_i - prev_q;
    assign interval_o    = interval_q;
    assign last_period_o = last_q;

    always_comb begin
        interval_d = interval_q;
        last_d     = last_q;
        if (change_o) begin
            interval_d = CNT_W'(1);
            last_d     = interval_q;
        end else if (interval_q != '1) begin
            interval_d = interval_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q   <= 1'b0;
            prev_q     <= 8'd0;
            interval_q <= '0;
            last_q     <= '0;
        end else begin
            primed_q   <= 1'b1;
            prev_q     <= count_i;
            interval_q <= interval_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: rtl/count_rate_monitor.sv
// rtl/count_rate_monitor.sv - recovers slow/fast counter speed from an observed count bus
module count_rate_monitor
    import count_rate_pkg::*;
#(
    parameter int SLOW_PERIOD = 100000000,
    parameter int FAST_PERIOD = 25000000,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       count_in,
    output logic             mode_valid,
    output logic             mode,
    output logic [CNT_W-1:0] last_period,
    output logic             step_err,
    output logic             period_err
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [MC_W-1:0]  LOCK_N   = MC_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] SLOW_LO  = CNT_W'(SLOW_PERIOD - TOL);
    localparam logic [CNT_W-1:0] SLOW_HI  = CNT_W'(SLOW_PERIOD + TOL);
    localparam logic [CNT_W-1:0] FAST_LO  = CNT_W'(FAST_PERIOD - TOL);
    localparam logic [CNT_W-1:0] FAST_HI  = CNT_W'(FAST_PERIOD + TOL);
    localparam logic [CNT_W-1:0] SLOW_TMO = CNT_W'(SLOW_PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0] FAST_TMO = CNT_W'(FAST_PERIOD + TOL + 1);

    logic             change;
    logic [7:0]       delta;
    logic [CNT_W-1:0] interval;

    count_interval_meter #(.CNT_W(CNT_W)) u_meter (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_i      (count_in),
        .change_o     (change),
        .delta_o      (delta),
        .interval_o   (interval),
        .last_period_o(last_period)
    );

    state_e          state_q, state_d;
    logic            cand_q, cand_d;
    logic [MC_W-1:0] match_q, match_d, match_next;
    logic            mode_q, mode_d;
    logic            valid_q;
    logic            step_err_q, step_err_d;
    logic            period_err_q, period_err_d;

    logic slow_in_tol, fast_in_tol, slow_match, fast_match, matched_mode;
    logic lock_in_tol, timeout_hit;

    assign slow_in_tol  = (interval >= SLOW_LO) && (interval <= SLOW_HI);
    assign fast_in_tol  = (interval >= FAST_LO) && (interval <= FAST_HI);
    assign slow_match   = (delta == STEP_SLOW) && slow_in_tol;
    assign fast_match   = (delta == STEP_FAST) && fast_in_tol;
    assign matched_mode = fast_match ? MODE_FAST : MODE_SLOW;
    assign lock_in_tol  = (mode_q == MODE_FAST) ? fast_in_tol : slow_in_tol;
    assign timeout_hit  = interval == ((mode_q == MODE_FAST) ? FAST_TMO : SLOW_TMO);

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        match_d      = match_q;
        match_next   = '0;
        mode_d       = mode_q;
        step_err_d   = 1'b0;
        period_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (change) begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
            end
            ACQUIRE: begin
                if (change) begin
                    if (slow_match || fast_match) begin
                        match_next = (matched_mode == cand_q) ? match_q + MC_W'(1) : MC_W'(1);
                        match_d    = match_next;
                        cand_d     = matched_mode;
                        if (match_next == LOCK_N) begin
                            state_d = LOCKED;
                            mode_d  = matched_mode;
                        end
                    end else begin
                        match_d = '0;
                        if (delta != STEP_SLOW && delta != STEP_FAST) step_err_d   = 1'b1;
                        else                                          period_err_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                // a change on the timeout cycle is classified, not timed out
                if (change && delta != step_for(mode_q)) begin
                    step_err_d = 1'b1;
                    state_d    = ACQUIRE;
                    match_d    = '0;
                end else if ((change && !lock_in_tol) || (!change && timeout_hit)) begin
                    period_err_d = 1'b1;
                    state_d      = ACQUIRE;
                    match_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                match_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cand_q       <= MODE_SLOW;
            match_q      <= '0;
            mode_q       <= MODE_SLOW;
            valid_q      <= 1'b0;
            step_err_q   <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            mode_q       <= mode_d;
            valid_q      <= (state_d == LOCKED);
            step_err_q   <= step_err_d;
            period_err_q <= period_err_d;
        end
    end

    assign mode_valid = valid_q;
    assign mode       = mode_q;
    assign step_err   = step_err_q;
    assign period_err = period_err_q;

endmodule

// File: tb/tb_count_rate_monitor.sv
// tb/tb_count_rate_monitor.sv - directed bench for count_rate_monitor with a cycle-count model
module tb_count_rate_monitor;

    localparam int SLOW   = 20;
    localparam int FAST   = 5;
    localparam int TOL    = 1;
    localparam int LOCKN  = 3;
    localparam int CNT_W  = 8;
    localparam int IV_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       count_in;
    logic             mode_valid, mode, step_err, period_err;
    logic [CNT_W-1:0] last_period;

    count_rate_monitor #(
        .SLOW_PERIOD(SLOW), .FAST_PERIOD(FAST), .TOL(TOL),
        .LOCK_COUNT(LOCKN), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .mode_valid (mode_valid),
        .mode       (mode),
        .last_period(last_period),
        .step_err   (step_err),
        .period_err (period_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    logic [7:0] cur;

    // model: interval is the cycle distance to the last change, clipped at IV_MAX
    int m_n, m_ref, m_streak, m_cand, m_lmode;
    bit m_primed, m_seen, m_locked;
    logic [7:0] m_prev;
    bit exp_valid, exp_mode, exp_step, exp_perr;
    int exp_last;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 1; m_ref = 1; m_streak = 0; m_cand = 0; m_lmode = 0;
        m_primed = 0; m_seen = 0; m_locked = 0; m_prev = 8'd0;
        exp_valid = 0; exp_mode = 0; exp_step = 0; exp_perr = 0; exp_last = 0;
    endtask

    task automatic model_tick();
        int iv, d, per;
        bit ch, slow_ok, fast_ok;
        if (!rst_n) begin
            model_reset();
            return;
        end
        iv = m_n - m_ref;
        if (iv > IV_MAX) iv = IV_MAX;
        ch = m_primed && (count_in != m_prev);
        d = int'(count_in) - int'(m_prev);
        if (d < 0) d += 256;
        slow_ok = ch && d == 1 && iabs(iv - SLOW) <= TOL;
        fast_ok = ch && d == 4 && iabs(iv - FAST) <= TOL;
        exp_step = 0;
        exp_perr = 0;
        if (ch) begin
            exp_last = iv;
            m_ref = m_n;
        end
        if (!m_seen) begin
            if (ch) begin m_seen = 1; m_streak = 0; end
        end else if (!m_locked) begin
            if (slow_ok || fast_ok) begin
                if (int'(fast_ok) == m_cand) m_streak++;
                else begin m_cand = int'(fast_ok); m_streak = 1; end
                if (m_streak == LOCKN) begin m_locked = 1; m_lmode = m_cand; end
            end else if (ch) begin
                m_streak = 0;
                if (d != 1 && d != 4) exp_step = 1;
                else exp_perr = 1;
            end
        end else begin
            per = (m_lmode != 0) ? FAST : SLOW;
            if (ch && d != ((m_lmode != 0) ? 4 : 1)) begin
                exp_step = 1; m_locked = 0; m_streak = 0;
            end else if (ch && iabs(iv - per) > TOL) begin
                exp_perr = 1; m_locked = 0; m_streak = 0;
            end else if (!ch && iv == per + TOL + 1) begin
                exp_perr = 1; m_locked = 0; m_streak = 0;
            end
        end
        exp_valid = m_locked;
        exp_mode  = (m_lmode != 0);
        m_primed  = 1;
        m_prev    = count_in;
        m_n++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mode_valid", 32'(mode_valid), 32'(exp_valid));
            if (exp_valid) check("mode", 32'(mode), 32'(exp_mode));
            check("last_period", 32'(last_period), 32'(exp_last));
            check("step_err", 32'(step_err), 32'(exp_step));
            check("period_err", 32'(period_err), 32'(exp_perr));
        end
    end

    task automatic tick(input logic [7:0] v);
        count_in = v;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic chg(input logic [7:0] v, input int p);
        repeat (p - 1) tick(cur);
        tick(v);
        cur = v;
    endtask

    initial begin
        rst_n = 1'b0;
        count_in = 8'h10;
        cur = 8'h10;
        model_reset();
        repeat (3) tick(cur);
        chk_en = 1'b1;
        check("rst_valid", 32'(mode_valid), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_last", 32'(last_period), 0);
        check("rst_step", 32'(step_err), 0);
        check("rst_perr", 32'(period_err), 0);
        rst_n = 1'b1;
        repeat (5) tick(cur);

        // slow lock
        for (int k = 1; k <= 4; k++) begin
            chg(8'h10 + 8'(k), SLOW);
            if (k == 3) check("slow_no_lock_yet", 32'(mode_valid), 0);
        end
        check("slow_lock_valid", 32'(mode_valid), 1);
        check("slow_lock_mode", 32'(mode), 0);
        check("slow_lock_last", 32'(last_period), 20);

        // tolerance edges
        chg(8'h15, 19);
        chg(8'h16, 21);
        check("tol21_valid", 32'(mode_valid), 1);
        check("tol21_last", 32'(last_period), 21);
        chg(8'h17, 22);
        check("tol22_perr", 32'(period_err), 1);
        check("tol22_valid", 32'(mode_valid), 0);
        for (int v = 8'h18; v <= 8'h30; v++) chg(8'(v), SLOW);
        check("relock_valid", 32'(mode_valid), 1);

        // step violation while locked slow
        chg(8'h32, SLOW);
        check("stepv_step", 32'(step_err), 1);
        check("stepv_perr", 32'(period_err), 0);
        check("stepv_valid", 32'(mode_valid), 0);
        tick(cur);
        check("stepv_pulse_end", 32'(step_err), 0);

        // fast lock through FC->00 wrap
        chg(8'hF4, FAST);
        check("fast_bad_jump", 32'(step_err), 1);
        chg(8'hF8, FAST);
        chg(8'hFC, FAST);
        check("fast_no_lock_yet", 32'(mode_valid), 0);
        chg(8'h00, FAST);
        check("fast_lock_valid", 32'(mode_valid), 1);
        check("fast_lock_mode", 32'(mode), 1);
        check("fast_wrap_step", 32'(step_err), 0);
        check("fast_lock_last", 32'(last_period), 5);

        // timeout while locked fast
        repeat (6) tick(cur);
        check("tmo_before_perr", 32'(period_err), 0);
        check("tmo_before_valid", 32'(mode_valid), 1);
        tick(cur);
        check("tmo_perr", 32'(period_err), 1);
        check("tmo_valid", 32'(mode_valid), 0);

        // interval saturation in ACQUIRE
        repeat (260) tick(cur);
        chg(8'h01, 1);
        check("sat_last", 32'(last_period), 255);
        check("sat_perr", 32'(period_err), 1);

        // relock slow, then reset mid-lock
        chg(8'h02, SLOW);
        chg(8'h03, SLOW);
        chg(8'h04, SLOW);
        check("relock2_valid", 32'(mode_valid), 1);
        check("relock2_mode", 32'(mode), 0);
        repeat (8) tick(cur);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", 32'(mode_valid), 0);
        check("midrst_last", 32'(last_period), 0);
        check("midrst_step", 32'(step_err), 0);
        check("midrst_perr", 32'(period_err), 0);
        repeat (2) tick(cur);
        rst_n = 1'b1;
        repeat (30) tick(cur);
        chg(8'h05, SLOW);
        check("post_rst_step", 32'(step_err), 0);
        check("post_rst_perr", 32'(period_err), 0);
        check("post_rst_valid", 32'(mode_valid), 0);
        repeat (5) tick(cur);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/count_rate_monitor.md
Name: count_rate_monitor

Overview:
- Receive-side companion to the team's dual-speed 8-bit counter: watches an 8-bit count bus and recovers which speed the source is running at.
- Speed modes: mode 0 = step +1 every SLOW_PERIOD cycles; mode 1 = step +4 every FAST_PERIOD cycles.
- Measures the interval between count changes and the step size, locks onto a mode, and flags step/period violations.
- Sits beside the counter in the bring-up/self-check path; count_in is synchronous to clk.

Parameters:
- SLOW_PERIOD, 100000000: expected cycles between changes in mode 0 (step 1).
- FAST_PERIOD, 25000000: expected cycles between changes in mode 1 (step 4).
- TOL, 2: allowed ± deviation in cycles on a measured period.
- LOCK_COUNT, 3: consecutive matching intervals required to lock.
- CNT_W, 32: interval counter width; must hold SLOW_PERIOD+TOL+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- count_in  in  8  observed count bus.
- mode_valid  out  1  high while LOCKED.
- mode  out  1  recovered mode (0 slow/+1, 1 fast/+4); meaningful only when mode_valid=1.
- last_period  out  CNT_W  cycles between the two most recent changes.
- step_err  out  1  one-cycle pulse: illegal or mismatched step.
- period_err  out  1  one-cycle pulse: interval out of tolerance, or timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, primed=0, prev_count=0, interval=0, match_cnt=0, all outputs 0.
- prev_count <= count_in every cycle.
- primed is set on the first clk after reset. Change detection is active only when primed=1, so the reset value never produces a false change.
- change = primed && (count_in != prev_count).
- delta = (count_in - prev_count) mod 256, 8-bit wrap: FF->00 gives 1; FC->00 gives 4.
- Interval counter:
  - On change: interval <= 1; last_period <= interval.
  - Otherwise: interval increments, saturating at all-ones.
  - The period reported at a change therefore equals the cycle distance between the two changes.
- Classification (combinational, on a change):
  - Slow match: delta==1 and |interval − SLOW_PERIOD| ≤ TOL.
  - Fast match: delta==4 and |interval − FAST_PERIOD| ≤ TOL.
- State IDLE: first change -> ACQUIRE, match_cnt=0. No error pulses in IDLE.
- State ACQUIRE, on change:
  - Slow or fast match with cand equal to the matched mode: match_cnt++.
  - Match with a different cand: cand <= matched mode, match_cnt=1.
  - No match: match_cnt=0. Pulse step_err if delta∉{1,4}, otherwise pulse period_err.
  - match_cnt reaching LOCK_COUNT -> LOCKED, mode<=cand, mode_valid=1 on the next cycle.
- State LOCKED:
  - On change, delta ≠ expected step for mode: step_err pulse -> ACQUIRE.
  - Else on change, period outside tolerance: period_err pulse -> ACQUIRE.
  - Timeout: no change and interval == expected+TOL+1 -> period_err pulse -> ACQUIRE.
  - On any exit, mode_valid drops the cycle after the error; match_cnt=0.
- Simultaneous change and timeout threshold: the change wins and is classified normally.
- Step error and period error in the same change: only step_err pulses.
- Interval saturation: no wrap; in ACQUIRE a saturated interval simply fails classification on the next change.
- Reset mid-operation returns to IDLE immediately with all outputs 0.
- All outputs are registered. Latency: the error pulse, and last_period update, appear on the cycle after the change is visible on count_in.

Decomposition:
- Package count_rate_pkg:
  - State enum: IDLE, ACQUIRE, LOCKED.
  - Mode constants: MODE_SLOW=0, MODE_FAST=1.
  - Step constants: STEP_SLOW=8'd1, STEP_FAST=8'd4.
- Sub-module count_interval_meter: prev_count register, primed flag, change detect, delta, saturating interval counter, last_period.
- Top level holds the FSM, classification and error pulses.

Test Plan (SLOW_PERIOD=20, FAST_PERIOD=5, TOL=1, LOCK_COUNT=3):
- Slow lock: count steps +1 every 20 cycles from 0x10 -> mode_valid=1 after the 4th change, mode=0, last_period=20, no error pulses.
- Fast lock with wrap: +4 every 5 cycles from 0xF4 through 0x00 -> mode_valid=1, mode=1, no step_err at FC->00.
- Step violation when locked slow: jump 0x30->0x32 at period 20 -> one step_err pulse, period_err stays 0, mode_valid drops, state ACQUIRE.
- Timeout when locked fast: count holds -> period_err pulse when interval reaches 7, mode_valid drops.
- Tolerance edges: slow intervals 19 and 21 keep lock; interval 22 -> period_err.
- Reset mid-lock: rst_n low for 2 cycles while LOCKED -> all outputs 0 immediately. After release, a constant count_in gives no change; the first real change enters ACQUIRE without error pulses.
